concat_serializer: RTL and testbench

- Downstream stage for the wide packed concatenations assembled in the datapath, such as `{elem3, elem2, elem1, elem0}`.
- Accepts one packed word of N_ITEM fields through a valid/ready handshake.
- Emits the fields one per cycle, leading (most-significant) field first, on a valid/ready item stream with a last flag.
- Lets wide concatenated buses cross to narrow links or arbiters without widening them.

---
 rtl/concat_serializer_if.sv | 42 ++++
 rtl/concat_serializer.sv | 91 +++++++++
 tb/tb_concat_serializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/concat_serializer_if.sv
// Handshake bundle between a wide-word producer, the serializer and a narrow item consumer.
// slave is the serializer side; master is the producer/consumer environment side.
interface concat_serializer_if #(
   parameter int N_ITEM = 4,
   parameter int ITEM_W = 8
);
   localparam int LEN_W = $clog2(N_ITEM + 1);

   logic                       i_in_valid;
   logic                       o_in_ready;
   logic [N_ITEM*ITEM_W-1:0]   i_in_data;
   logic [LEN_W-1:0]           i_in_len;
   logic                       o_out_valid;
   logic                       i_out_ready;
   logic [ITEM_W-1:0]          o_out_data;
   logic                       o_out_last;
   logic                       o_busy;

   modport slave (
      input  i_in_valid,
      input  i_in_data,
      input  i_in_len,
      input  i_out_ready,
      output o_in_ready,
      output o_out_valid,
      output o_out_data,
      output o_out_last,
      output o_busy
   );

   modport master (
      output i_in_valid,
      output i_in_data,
      output i_in_len,
      output i_out_ready,
      input  o_in_ready,
      input  o_out_valid,
      input  o_out_data,
      input  o_out_last,
      input  o_busy
   );
endinterface

// File: rtl/concat_serializer.sv
// Splits a packed word into ITEM_W items, leading field first; first item one cycle after accept.
// Output holds under i_out_ready low; a new word is taken in the same cycle the last item leaves.
module concat_serializer #(
   parameter int N_ITEM = 4,
   parameter int ITEM_W = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   concat_serializer_if.slave    bus
);
   localparam int LEN_W  = $clog2(N_ITEM + 1);
   localparam int WORD_W = N_ITEM * ITEM_W;

   generate
      if (N_ITEM < 2 || ITEM_W < 1) begin : g_bad_param
         $error("concat_serializer: N_ITEM must be >= 2 and ITEM_W >= 1");
      end
   endgenerate

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state;
   logic [WORD_W-1:0]    shreg;
   logic [LEN_W-1:0]     cnt;
   logic [LEN_W-1:0]     eff_len;
   logic                 last_item;
   logic                 in_fire;
   logic                 out_fire;

   // Zero or oversized lengths mean "the whole word".
   always_comb begin
      eff_len = bus.i_in_len;
      if (bus.i_in_len == '0 || bus.i_in_len > LEN_W'(N_ITEM)) begin
         eff_len = LEN_W'(N_ITEM);
      end
   end

   assign last_item = (state == SHIFT) && (cnt == LEN_W'(1));

   // Ready in SHIFT follows i_out_ready combinationally so back-to-back words leave no bubble.
   assign bus.o_in_ready = !i_rst && ((state == IDLE) || (last_item && bus.i_out_ready));

   assign in_fire  = bus.i_in_valid && bus.o_in_ready;
   assign out_fire = (state == SHIFT) && bus.i_out_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_fire) begin
                  shreg <= bus.i_in_data;
                  cnt   <= eff_len;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (out_fire) begin
                  if (last_item) begin
                     if (in_fire) begin
                        shreg <= bus.i_in_data;
                        cnt   <= eff_len;
                     end else begin
                        shreg <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                     end
                  end else begin
                     shreg <= {shreg[WORD_W-ITEM_W-1:0], {ITEM_W{1'b0}}};
                     cnt   <= cnt - LEN_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               shreg <= '0;
            end
         endcase
      end
   end

   assign bus.o_out_valid = (state == SHIFT);
   assign bus.o_busy      = (state == SHIFT);
   assign bus.o_out_data  = shreg[WORD_W-1 -: ITEM_W];
   assign bus.o_out_last  = last_item;

endmodule

// File: tb/tb_concat_serializer.sv
// Bench for concat_serializer: directed scenarios plus random traffic against a queue-based item model.
module tb_concat_serializer;
   localparam int N_ITEM = 4;
   localparam int ITEM_W = 8;
   localparam int LEN_W  = $clog2(N_ITEM + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   concat_serializer_if #(.N_ITEM(N_ITEM), .ITEM_W(ITEM_W)) bus ();

   logic                     in_valid = 1'b0;
   logic [N_ITEM*ITEM_W-1:0] in_data  = '0;
   logic [LEN_W-1:0]         in_len   = '0;
   logic                     out_ready = 1'b0;

   assign bus.i_in_valid  = in_valid;
   assign bus.i_in_data   = in_data;
   assign bus.i_in_len    = in_len;
   assign bus.i_out_ready = out_ready;

   concat_serializer #(.N_ITEM(N_ITEM), .ITEM_W(ITEM_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [ITEM_W-1:0] d;
      logic              l;
   } item_t;

   item_t             q[$];
   logic              after_rst  = 1'b0;
   logic              prev_stall = 1'b0;
   logic [ITEM_W-1:0] prev_data;
   logic              prev_last;
   int                items_seen = 0;

   // Reference: an accepted word becomes a list of its L leading fields; the stream must present them in order.
   always @(negedge clk) begin
      if (rst) begin
         check("in_ready_in_reset", bus.o_in_ready, 1'b0);
         q.delete();
         after_rst  = 1'b1;
         prev_stall = 1'b0;
      end else begin
         int    n;
         logic  exp_rdy;
         n = q.size();
         check("out_valid", bus.o_out_valid, n > 0);
         check("busy", bus.o_busy, n > 0);
         exp_rdy = (n == 0) || (q[0].l && out_ready);
         check("in_ready", bus.o_in_ready, exp_rdy);
         if (n > 0) begin
            check("out_data", bus.o_out_data, q[0].d);
            check("out_last", bus.o_out_last, q[0].l);
         end
         if (after_rst) begin
            check("rst_out_data", bus.o_out_data, '0);
            check("rst_out_last", bus.o_out_last, 1'b0);
            after_rst = 1'b0;
         end
         if (prev_stall) begin
            check("stall_data", bus.o_out_data, prev_data);
            check("stall_last", bus.o_out_last, prev_last);
         end
         prev_stall = bus.o_out_valid && !out_ready;
         prev_data  = bus.o_out_data;
         prev_last  = bus.o_out_last;
         if (n > 0 && out_ready) begin
            void'(q.pop_front());
            items_seen++;
         end
         if (in_valid && bus.o_in_ready) begin
            int L;
            L = (in_len == 0 || in_len > N_ITEM) ? N_ITEM : int'(in_len);
            for (int k = 0; k < L; k++) begin
               item_t it;
               it.d = in_data[(N_ITEM-k)*ITEM_W-1 -: ITEM_W];
               it.l = (k == L - 1);
               q.push_back(it);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the word valid until the handshake edge, bounded by a cycle budget.
   task automatic send(input logic [31:0] d, input logic [LEN_W-1:0] l);
      logic got;
      got      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_len   = l;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         got = bus.o_in_ready;
         step();
      end
      if (!got) check("send_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int seen0;
      step();
      step();
      rst = 1'b0;
      step();

      // Whole word, then a stalled copy.
      out_ready = 1'b1;
      send(32'hA1B2C3D4, 3'd0);
      idle_cycles(5);
      send(32'hA1B2C3D4, 3'd0);
      step();
      out_ready = 1'b0;
      idle_cycles(2);
      out_ready = 1'b1;
      idle_cycles(5);

      // Short and oversized lengths.
      seen0 = items_seen;
      send(32'hA1B2C3D4, 3'd2);
      idle_cycles(4);
      check("len2_count", items_seen - seen0, 2);
      seen0 = items_seen;
      send(32'hA1B2C3D4, 3'd7);
      idle_cycles(6);
      check("len7_count", items_seen - seen0, 4);

      // Back-to-back words and single-item words.
      send(32'h01020304, 3'd0);
      send(32'h05060708, 3'd0);
      idle_cycles(6);
      send(32'h11111111, 3'd1);
      send(32'h22222222, 3'd1);
      send(32'h33333333, 3'd1);
      idle_cycles(3);

      // Reset while the second item is presented.
      send(32'hA1B2C3D4, 3'd0);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      seen0 = items_seen;
      send(32'hDEADBEEF, 3'd0);
      idle_cycles(6);
      check("post_rst_count", items_seen - seen0, 4);

      // Random traffic.
      for (int c = 0; c < 2000; c++) begin
         rst       = ($urandom_range(0, 79) == 0);
         in_valid  = $urandom_range(0, 1) == 1;
         in_data   = $urandom;
         in_len    = LEN_W'($urandom_range(0, 7));
         out_ready = $urandom_range(0, 3) != 0;
         step();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle_cycles(10);
      check("drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
